// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Brief    : Shared types and sizing helpers for the UART receive deframer.
//             Optional build macro used by the deframer: UART_RX_MAJORITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

   // Frame FSM states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } rx_state_t;

   // Oversample tick at which a bit is centred: MID_TICK = OVERSAMPLE/2-1
   function automatic int f_mid_tick(input int oversample);
      return oversample / 2 - 1;
   endfunction

   // Width of the per-bit oversample tick counter
   function automatic int f_tick_cnt_w(input int oversample);
      return $clog2(oversample);
   endfunction

   // Width of the received-data-bit counter (must hold DATA_BITS)
   function automatic int f_bit_cnt_w(input int data_bits);
      return $clog2(data_bits + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick_gen
//  Brief    : Oversampling baud prescaler. Emits one tick every baud_div+1
//             clocks; a synchronous clear holds the count at zero so the
//             first tick after release lands baud_div+1 clocks later.
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_clear,
   input  logic [DIV_WIDTH-1:0] i_baud_div,
   output logic                 o_tick
);

   logic [DIV_WIDTH-1:0] r_cnt;
   logic                 w_terminal;

   // >= rather than == so a divisor lowered mid-count cannot run the counter round
   assign w_terminal = (r_cnt >= i_baud_div);
   assign o_tick     = !i_clear && w_terminal;

   // Prescaler count: wraps at the terminal count, parked at zero while cleared
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clear || w_terminal) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_deframer
//  Brief    : UART receive deframer: input synchroniser, baud prescaler,
//             start-bit validation, configurable frame FSM (data bits,
//             parity, one/two stop bits) and valid/ready word delivery with
//             parity, framing and overrun flags.
//             Build macro UART_RX_MAJORITY_EN: 2-of-3 majority bit sampling.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_deframer
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int LSB_FIRST  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_enable,
   input  logic [DIV_WIDTH-1:0] i_baud_div,
   input  logic                 i_parity_en,
   input  logic                 i_parity_odd,
   input  logic                 i_two_stop,
   input  logic                 i_serial_in,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun_err,
   output logic                 o_busy
);

   localparam int                   c_TICK_W    = f_tick_cnt_w(OVERSAMPLE);
   localparam int                   c_BIT_W     = f_bit_cnt_w(DATA_BITS);
   localparam logic [c_TICK_W-1:0]  c_MID       = c_TICK_W'(f_mid_tick(OVERSAMPLE));
   localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
   localparam logic [c_BIT_W-1:0]   c_BITS_LAST = c_BIT_W'(DATA_BITS - 1);

   rx_state_t              r_state;
   rx_state_t              w_state_nxt;
   logic                   r_sync1, r_sync2;
   logic                   w_rxs;
   logic                   w_tick;
   logic [c_TICK_W-1:0]    r_tick_cnt;
   logic                   w_sample_evt;
   logic                   w_bit;
   logic                   w_start_det;
   logic                   w_complete;
   logic [DATA_BITS-1:0]   r_shift;
   logic [c_BIT_W-1:0]     r_bit_cnt;
   logic                   r_par_acc;
   logic                   r_par_err_p;
   logic                   r_frm_err_p;
   logic                   r_par_en, r_par_odd, r_two_stop;
   logic                   w_frame_final;
   logic [DATA_BITS-1:0]   r_rx_data;
   logic                   r_rx_valid, r_parity_err, r_frame_err, r_overrun;

   // Two-flop synchroniser; resets to the idle-high line level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_serial_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   uart_baud_tick_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_gen (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (r_state == S_IDLE),
      .i_baud_div (i_baud_div),
      .o_tick     (w_tick)
   );

   // Oversample tick counter: zero in IDLE, free-runs modulo OVERSAMPLE within a frame
   // so every bit is sampled exactly OVERSAMPLE ticks after the previous one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   localparam logic [c_TICK_W-1:0] c_MID_M1 = c_MID - 1'b1;
   localparam logic [c_TICK_W-1:0] c_MID_P1 = c_MID + 1'b1;

   logic r_maj0, r_maj1;

   // Capture the two early votes; the third vote is the live line at decision time
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_maj0 <= 1'b1;
         r_maj1 <= 1'b1;
      end else if (w_tick) begin
         if (r_tick_cnt == c_MID_M1) r_maj0 <= w_rxs;
         if (r_tick_cnt == c_MID)    r_maj1 <= w_rxs;
      end
   end

   assign w_sample_evt = w_tick && (r_tick_cnt == c_MID_P1);
   assign w_bit        = (r_maj0 & r_maj1) | (r_maj0 & w_rxs) | (r_maj1 & w_rxs);
`else
   assign w_sample_evt = w_tick && (r_tick_cnt == c_MID);
   assign w_bit        = w_rxs;
`endif

   // Frame state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic plus start-detect and completion strobes
   always_comb begin
      w_state_nxt = r_state;
      w_start_det = 1'b0;
      w_complete  = 1'b0;
      if (!i_enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_rxs) begin
                  w_state_nxt = S_START;
                  w_start_det = 1'b1;
               end
            end
            S_START: begin
               if (w_sample_evt) w_state_nxt = w_bit ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (w_sample_evt && (r_bit_cnt == c_BITS_LAST))
                  w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
               if (w_sample_evt) w_state_nxt = S_STOP1;
            end
            S_STOP1: begin
               if (w_sample_evt) begin
                  if (r_two_stop) begin
                     w_state_nxt = S_STOP2;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_complete  = 1'b1;
                  end
               end
            end
            S_STOP2: begin
               if (w_sample_evt) begin
                  w_state_nxt = S_IDLE;
                  w_complete  = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame datapath: config latch, word assembly, running parity and pending error flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_par_acc   <= 1'b0;
         r_par_err_p <= 1'b0;
         r_frm_err_p <= 1'b0;
         r_par_en    <= 1'b0;
         r_par_odd   <= 1'b0;
         r_two_stop  <= 1'b0;
      end else if (w_start_det) begin
         r_bit_cnt   <= '0;
         r_par_acc   <= 1'b0;
         r_par_err_p <= 1'b0;
         r_frm_err_p <= 1'b0;
         r_par_en    <= i_parity_en;
         r_par_odd   <= i_parity_odd;
         r_two_stop  <= i_two_stop;
      end else if (w_sample_evt) begin
         case (r_state)
            S_DATA: begin
               if (LSB_FIRST != 0) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
               else                r_shift <= {r_shift[DATA_BITS-2:0], w_bit};
               r_bit_cnt <= r_bit_cnt + 1'b1;
               r_par_acc <= r_par_acc ^ w_bit;
            end
            S_PARITY: r_par_err_p <= (w_bit != (r_par_acc ^ r_par_odd));
            S_STOP1,
            S_STOP2:  if (!w_bit) r_frm_err_p <= 1'b1;
            default: ;
         endcase
      end
   end

   // The final stop sample is folded in directly since the pending flag has not yet seen it
   assign w_frame_final = r_frm_err_p | ~w_bit;

   // Host handshake: load on completion when the slot is free (or freed this cycle), else flag overrun
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= w_complete && r_rx_valid && !i_rx_ready;
         if (w_complete && (!r_rx_valid || i_rx_ready)) begin
            r_rx_data    <= r_shift;
            r_parity_err <= r_par_err_p;
            r_frame_err  <= w_frame_final;
            r_rx_valid   <= 1'b1;
         end else if (r_rx_valid && i_rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign o_rx_data     = r_rx_data;
   assign o_rx_valid    = r_rx_valid;
   assign o_parity_err  = r_parity_err;
   assign o_frame_err   = r_frame_err;
   assign o_overrun_err = r_overrun;
   assign o_busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
